// File: rtl/ni_tx_arbiter.sv
// ni_tx_arbiter: transmit-side network interface.
// Each core channel queues {dest router, neuron addr} packets into its own
// FIFO; a round-robin arbiter drains at most one head per cycle into either
// the NoC injection register or the local loopback register. Stage p0 is the
// FIFO head / arbitration point, stage p1 is the sink holding register.
module ni_tx_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDRSIZE = 2,
  parameter int MSB_SLOT = 5,
  localparam int DSIZE   = 2**MSB_SLOT,
  localparam int RSIZE   = 2**(MSB_SLOT-1),
  parameter logic [RSIZE-1:0] LOCAL_ID = 'h0003
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         core_wen,
  input  logic [NUM_CH*RSIZE-1:0]   core_waddr,
  input  logic [NUM_CH*RSIZE-1:0]   core_wdata,
  output logic [NUM_CH-1:0]         core_wfull,
  output logic                      noc_valid,
  output logic [DSIZE-1:0]          noc_data,
  input  logic                      noc_ready,
  output logic                      loc_valid,
  output logic [DSIZE-1:0]          loc_data,
  input  logic                      loc_ready,
  output logic [15:0]               drop_cnt
);

  localparam int DEPTH = 2**ADDRSIZE;
  localparam int CNT_W = ADDRSIZE + 1;
  localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Drop counter never wraps; it pins at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Channel index base+k, wrapped into 0..NUM_CH-1 (k < NUM_CH).
  function automatic logic [RR_W-1:0] wrap_idx(input logic [RR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return RR_W'(s);
  endfunction

  // Per-channel FIFO storage and control
  logic [DSIZE-1:0]    mem  [NUM_CH][DEPTH];
  logic [ADDRSIZE-1:0] wptr [NUM_CH];
  logic [ADDRSIZE-1:0] rptr [NUM_CH];
  logic [CNT_W-1:0]    cnt  [NUM_CH];

  logic [NUM_CH-1:0]   full_p0, empty_p0, push_p0, pop_p0, drop_p0, head_loc_p0, cand_p0;
  logic [DSIZE-1:0]    head_p0 [NUM_CH];
  logic [15:0]         drop_n_p0;

  logic [RR_W-1:0]     rr, gnt_idx_p0;
  logic                gnt_vld_p0;
  logic                noc_free_p0, loc_free_p0;

  logic                noc_vld_p1, loc_vld_p1;
  logic [DSIZE-1:0]    noc_data_p1, loc_data_p1;
  logic [15:0]         drop_cnt_q;

  // ---- stage p0: FIFO heads, sink availability, candidate selection ----

  assign noc_free_p0 = ~noc_vld_p1 | noc_ready;
  assign loc_free_p0 = ~loc_vld_p1 | loc_ready;

  // Per-channel status from registered counts, head decode and candidacy.
  always_comb begin
    drop_n_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full_p0[i]     = (cnt[i] == CNT_W'(DEPTH));
      empty_p0[i]    = (cnt[i] == '0);
      push_p0[i]     = core_wen[i] & ~full_p0[i];
      drop_p0[i]     = core_wen[i] & full_p0[i];
      head_p0[i]     = mem[i][rptr[i]];
      head_loc_p0[i] = (head_p0[i][DSIZE-1 -: RSIZE] == LOCAL_ID);
      cand_p0[i]     = ~empty_p0[i] & (head_loc_p0[i] ? loc_free_p0 : noc_free_p0);
      drop_n_p0      = drop_n_p0 + 16'(drop_p0[i]);
    end
  end

  // Round-robin search starting at rr; first eligible channel wins the pop.
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    pop_p0     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_vld_p0 && cand_p0[wrap_idx(rr, k)]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = wrap_idx(rr, k);
      end
    end
    if (gnt_vld_p0) pop_p0[gnt_idx_p0] = 1'b1;
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_p0[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop_p0[i])  rptr[i] <= rptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CNT_W'(push_p0[i]) - CNT_W'(pop_p0[i]);
      end
    end
  end

  // FIFO storage write; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_p0[i]) mem[i][wptr[i]] <= {core_waddr[i*RSIZE +: RSIZE], core_wdata[i*RSIZE +: RSIZE]};
    end
  end

  // Arbiter pointer advances past the granted channel, holds when idle.
  always_ff @(posedge clk) begin
    if (reset) rr <= '0;
    else if (gnt_vld_p0) rr <= wrap_idx(gnt_idx_p0, 1);
  end

  // Saturating count of writes refused because the channel was full.
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= sat_add16(drop_cnt_q, drop_n_p0);
  end

  // ---- stage p1: sink holding registers ----

  // Each sink reloads on grant (even in its own transfer cycle), else clears on transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      noc_vld_p1  <= 1'b0;
      noc_data_p1 <= '0;
      loc_vld_p1  <= 1'b0;
      loc_data_p1 <= '0;
    end else begin
      if (gnt_vld_p0 && !head_loc_p0[gnt_idx_p0]) begin
        noc_vld_p1  <= 1'b1;
        noc_data_p1 <= head_p0[gnt_idx_p0];
      end else if (noc_vld_p1 && noc_ready) begin
        noc_vld_p1  <= 1'b0;
      end
      if (gnt_vld_p0 && head_loc_p0[gnt_idx_p0]) begin
        loc_vld_p1  <= 1'b1;
        loc_data_p1 <= head_p0[gnt_idx_p0];
      end else if (loc_vld_p1 && loc_ready) begin
        loc_vld_p1  <= 1'b0;
      end
    end
  end

  assign core_wfull = full_p0;
  assign noc_valid  = noc_vld_p1;
  assign noc_data   = noc_data_p1;
  assign loc_valid  = loc_vld_p1;
  assign loc_data   = loc_data_p1;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ni_tx_arbiter.sv
// Bench for ni_tx_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_ni_tx_arbiter;

  localparam int NCH      = 2;
  localparam int ADDRSIZE = 2;
  localparam int MSB_SLOT = 5;
  localparam int DEPTH    = 4;
  localparam logic [15:0] LID = 16'h0003;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  core_wen;
  logic [31:0] core_waddr, core_wdata;
  logic [1:0]  core_wfull;
  logic        noc_valid, noc_ready, loc_valid, loc_ready;
  logic [31:0] noc_data, loc_data;
  logic [15:0] drop_cnt;

  ni_tx_arbiter #(
    .NUM_CH(NCH), .ADDRSIZE(ADDRSIZE), .MSB_SLOT(MSB_SLOT), .LOCAL_ID(LID)
  ) dut (
    .clk(clk), .reset(reset),
    .core_wen(core_wen), .core_waddr(core_waddr), .core_wdata(core_wdata),
    .core_wfull(core_wfull),
    .noc_valid(noc_valid), .noc_data(noc_data), .noc_ready(noc_ready),
    .loc_valid(loc_valid), .loc_data(loc_data), .loc_ready(loc_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one queue per channel, one register per sink.
  logic [31:0] mq [NCH][$];
  bit          m_noc_v = 1'b0, m_loc_v = 1'b0;
  logic [31:0] m_noc_d = '0, m_loc_d = '0;
  int          m_rr = 0;
  int          m_drop = 0;

  task automatic model_step();
    bit [NCH-1:0] full;
    bit nf, lf, is_loc;
    int g, idx, ndrop;
    logic [31:0] pkt;
    if (reset) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_noc_v = 0; m_noc_d = '0; m_loc_v = 0; m_loc_d = '0;
      m_rr = 0; m_drop = 0;
      return;
    end
    for (int i = 0; i < NCH; i++) full[i] = (mq[i].size() == DEPTH);
    nf = !m_noc_v || noc_ready;
    lf = !m_loc_v || loc_ready;
    if (m_noc_v && noc_ready) m_noc_v = 0;
    if (m_loc_v && loc_ready) m_loc_v = 0;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      idx = (m_rr + k) % NCH;
      if (g < 0 && mq[idx].size() > 0) begin
        pkt = mq[idx][0];
        is_loc = (pkt[31:16] == LID);
        if (is_loc ? lf : nf) g = idx;
      end
    end
    if (g >= 0) begin
      pkt = mq[g].pop_front();
      if (pkt[31:16] == LID) begin m_loc_v = 1; m_loc_d = pkt; end
      else begin m_noc_v = 1; m_noc_d = pkt; end
      m_rr = (g + 1) % NCH;
    end
    ndrop = 0;
    for (int i = 0; i < NCH; i++) begin
      if (core_wen[i]) begin
        if (full[i]) ndrop++;
        else mq[i].push_back({core_waddr[i*16 +: 16], core_wdata[i*16 +: 16]});
      end
    end
    m_drop = (m_drop + ndrop > 65535) ? 65535 : m_drop + ndrop;
  endtask

  task automatic compare_all();
    chk_eq("noc_valid", noc_valid, m_noc_v);
    chk_eq("noc_data", noc_data, m_noc_d);
    chk_eq("loc_valid", loc_valid, m_loc_v);
    chk_eq("loc_data", loc_data, m_loc_d);
    for (int i = 0; i < NCH; i++) chk_eq("core_wfull", core_wfull[i], (mq[i].size() == DEPTH));
    chk_eq("drop_cnt", drop_cnt, m_drop);
  endtask

  // Inputs are set after a falling edge; model and DUT advance on the rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_wr(input int ch, input bit en, input logic [15:0] a, input logic [15:0] d);
    core_wen[ch] = en;
    core_waddr[ch*16 +: 16] = a;
    core_wdata[ch*16 +: 16] = d;
  endtask

  task automatic clr_wr();
    core_wen = '0; core_waddr = '0; core_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_wr();
    cycle();
    reset = 1'b0;
  endtask

  int          deliv;
  logic [31:0] exp_d;
  logic [15:0] rr_base;

  initial begin
    reset = 1'b1; clr_wr(); noc_ready = 1'b0; loc_ready = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk_eq("rst_noc_valid", noc_valid, 0);
    chk_eq("rst_noc_data", noc_data, 0);
    chk_eq("rst_loc_valid", loc_valid, 0);
    chk_eq("rst_loc_data", loc_data, 0);
    chk_eq("rst_wfull", core_wfull, 0);
    chk_eq("rst_drop", drop_cnt, 0);
    reset = 1'b0;

    // Basic NoC packet: write c0, valid only in c2.
    do_reset();
    noc_ready = 1'b1; loc_ready = 1'b0;
    set_wr(0, 1, 16'h0005, 16'h0012);
    cycle();
    chk_eq("basic_c1_v", noc_valid, 0);
    clr_wr();
    cycle();
    chk_eq("basic_c2_v", noc_valid, 1);
    chk_eq("basic_c2_d", noc_data, 32'h0005_0012);
    chk_eq("basic_loc_v", loc_valid, 0);
    cycle();
    chk_eq("basic_c3_v", noc_valid, 0);

    // Loopback packet from channel 1.
    do_reset();
    noc_ready = 1'b0; loc_ready = 1'b1;
    set_wr(1, 1, 16'h0003, 16'h00AB);
    cycle();
    chk_eq("loop_c1_v", loc_valid, 0);
    clr_wr();
    cycle();
    chk_eq("loop_c2_v", loc_valid, 1);
    chk_eq("loop_c2_d", loc_data, 32'h0003_00AB);
    chk_eq("loop_noc_v", noc_valid, 0);
    cycle();
    chk_eq("loop_c3_v", loc_valid, 0);

    // Fill channel 0 with the NoC stalled; sixth write is dropped.
    do_reset();
    noc_ready = 1'b0; loc_ready = 1'b0;
    for (int d = 1; d <= 6; d++) begin
      if (d == 5) chk_eq("full_c4", core_wfull[0], 0);
      if (d == 6) chk_eq("full_c5", core_wfull[0], 1);
      set_wr(0, 1, 16'h0005, 16'(d));
      cycle();
    end
    clr_wr();
    chk_eq("full_drop", drop_cnt, 1);
    noc_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk_eq("drain_v", noc_valid, 1);
      chk_eq("drain_d", noc_data, {16'h0005, 16'(k)});
      cycle();
    end
    chk_eq("drain_end_v", noc_valid, 0);
    chk_eq("drain_wfull", core_wfull[0], 0);

    // Round-robin alternation between two preloaded channels.
    do_reset();
    noc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_wr(0, 1, 16'h0005, 16'h0A00 + 16'(k));
      set_wr(1, 1, 16'h0005, 16'h0B00 + 16'(k));
      cycle();
    end
    clr_wr();
    noc_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      rr_base = (j % 2 == 1) ? 16'h0B00 : 16'h0A00;
      exp_d = {16'h0005, rr_base + 16'(j / 2)};
      chk_eq("rr_v", noc_valid, 1);
      chk_eq("rr_d", noc_data, exp_d);
      cycle();
    end

    // Blocked NoC channel must not stall loopback traffic on the other channel.
    do_reset();
    noc_ready = 1'b0; loc_ready = 1'b1;
    set_wr(0, 1, 16'h0005, 16'h00C1); cycle();
    set_wr(0, 1, 16'h0005, 16'h00C2); cycle();
    clr_wr();
    set_wr(1, 1, 16'h0003, 16'h00D1); cycle();
    set_wr(1, 1, 16'h0003, 16'h00D2); cycle();
    clr_wr();
    deliv = 0;
    for (int j = 0; j < 4; j++) begin
      if (loc_valid) begin
        chk_eq("hol_loc_d", loc_data, (deliv == 0) ? 32'h0003_00D1 : 32'h0003_00D2);
        deliv++;
      end
      chk_eq("hol_noc_v", noc_valid, 1);
      chk_eq("hol_noc_d", noc_data, 32'h0005_00C1);
      cycle();
    end
    chk_eq("hol_loc_cnt", deliv, 2);

    // Reset in the middle of traffic discards everything.
    do_reset();
    noc_ready = 1'b0; loc_ready = 1'b0;
    for (int d = 1; d <= 6; d++) begin
      set_wr(0, 1, 16'h0005, 16'(d));
      cycle();
    end
    clr_wr();
    chk_eq("mid_pre_v", noc_valid, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk_eq("mid_noc_v", noc_valid, 0);
    chk_eq("mid_noc_d", noc_data, 0);
    chk_eq("mid_loc_v", loc_valid, 0);
    chk_eq("mid_wfull", core_wfull, 0);
    chk_eq("mid_drop", drop_cnt, 0);
    noc_ready = 1'b1;
    set_wr(0, 1, 16'h0005, 16'h0077);
    cycle();
    chk_eq("mid_t1_v", noc_valid, 0);
    clr_wr();
    cycle();
    chk_eq("mid_t2_v", noc_valid, 1);
    chk_eq("mid_t2_d", noc_data, 32'h0005_0077);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        logic [15:0] dst;
        case ($urandom_range(0, 3))
          0: dst = 16'h0003;
          1: dst = 16'h0005;
          2: dst = 16'h0003;
          default: dst = 16'h0009;
        endcase
        set_wr(ch, ($urandom_range(0, 2) != 0), dst, 16'($urandom));
      end
      noc_ready = ($urandom_range(0, 3) != 0);
      loc_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 1'b0;
    clr_wr();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ni_tx_arbiter.md
# ni_tx_arbiter

Multi-channel transmit-side network interface between one or more neuron cores and the router. Each core channel writes spike packets (destination router + neuron address) into its own FIFO. A round-robin arbiter drains the FIFOs into two sinks: the NoC injection port, or a local loopback port when the destination equals this router's ID. Both sinks use a valid/ready handshake.

## Interface
Parameters:
- NUM_CH, 2, number of core write channels (≥1)
- ADDRSIZE, 2, per-channel FIFO depth = 2^ADDRSIZE
- MSB_SLOT, 5, packet width DSIZE = 2^MSB_SLOT; half-width RSIZE = 2^(MSB_SLOT-1)
- LOCAL_ID, 16'h0003, RSIZE-bit ID of this router

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- core_wen  in  NUM_CH  per-channel write strobe
- core_waddr  in  NUM_CH*RSIZE  destination router ID; channel i at [i*RSIZE +: RSIZE]
- core_wdata  in  NUM_CH*RSIZE  neuron address; same packing
- core_wfull  out  NUM_CH  channel FIFO full
- noc_valid  out  1  NoC packet valid
- noc_data  out  DSIZE  {dest router, neuron addr}
- noc_ready  in  1  NoC accepts
- loc_valid  out  1  loopback packet valid
- loc_data  out  DSIZE  {dest router, neuron addr}
- loc_ready  in  1  local sink accepts
- drop_cnt  out  16  saturating count of refused writes

## Operation
- Packet = {core_waddr[i], core_wdata[i]}; destination = upper RSIZE bits.
- Per-channel FIFO: depth 2^ADDRSIZE, count width ADDRSIZE+1. Write accepted when core_wen[i] & !core_wfull[i]. core_wfull[i] = (count == depth), decoded from the registered count.
- A write when full is dropped. drop_cnt increments by the number of channels dropping that cycle and saturates at 16'hFFFF.
- Sink select: dest == LOCAL_ID → loopback register, else NoC register.
- Each sink has one output holding register. The register is "free" when !valid, or when valid & ready in the current cycle.
- Arbiter: at most one pop per cycle. Candidate = non-empty FIFO whose head's sink register is free. Search order starts at pointer rr and wraps (rr, rr+1, …). On grant g: pop the head, load the sink register, valid=1 next edge, rr ← (g+1) mod NUM_CH. No candidate → rr unchanged.
- Head-of-line blocking is per channel only. A channel blocked on one sink never stalls channels targeting the other sink.
- Per-channel order is preserved. Packets are never duplicated.
- FIFO has no bypass: a written packet becomes visible at the head on the next cycle.
- Simultaneous push and pop on the same FIFO is allowed and leaves count unchanged.
- Write into a full FIFO is refused even if that FIFO pops in the same cycle, because wfull is registered-state based.

## Timing
- Reset values: core_wfull=0, noc_valid=0, noc_data=0, loc_valid=0, loc_data=0, drop_cnt=0, rr=0, all FIFOs empty.
- Reset mid-operation clears everything at the next edge. Queued and in-flight packets are discarded. No output is asserted in the cycle after reset.
- Latency: write at cycle t → head at t+1 → granted at t+1 → valid at t+2 (minimum, sink free).
- valid stays high and data stays stable until ready. Transfer occurs on valid & ready at the edge.
- A sink register reloads in its transfer cycle, so back-to-back packets give 1 packet/cycle aggregate across both sinks.
- ready has no combinational path to core_wfull.

## Test plan
Common config: NUM_CH=2, ADDRSIZE=2, MSB_SLOT=5, LOCAL_ID=16'h0003.
- Basic NoC: ch0 writes waddr 16'h0005, wdata 16'h0012 at c0; noc_ready=1 → noc_valid=1 only in c2 with noc_data=32'h0005_0012; loc_valid stays 0.
- Loopback: ch1 writes 16'h0003/16'h00AB; loc_ready=1 → loc_valid in c2 with loc_data=32'h0003_00AB; noc_valid stays 0.
- Full/drop: noc_ready=0; ch0 writes dest 16'h0005 on c0..c5 with data 1..6.
  - core_wfull[0] rises in c5 and the 6th write is dropped; drop_cnt=1.
  - Then noc_ready=1 → data 1..5 out in order on consecutive cycles, and core_wfull falls.
- Round-robin: ch0 and ch1 each preloaded with 3 NoC packets, then noc_ready=1 → output order ch0,ch1,ch0,ch1,ch0,ch1, one per cycle.
- HOL isolation: noc_ready=0; ch0 holds 2 NoC packets; ch1 writes 2 loopback packets; loc_ready=1 → both ch1 packets delivered on loc while noc_valid stays held with ch0's first packet.
- Reset mid-flight: FIFOs partly full and noc_valid=1; assert reset for 1 cycle → next cycle all outputs 0, drop_cnt=0. A fresh write afterwards emerges at t+2.
